// File: rtl/inst_cache.sv
// -----------------------------------------------------------------------------
// inst_cache
//
// Instruction-side cache for the fetch stage. It sits behind the PC and turns
// the registered fetch address into an instruction word for IF_ID.
//
// Organisation: direct mapped, 2^INDEX_BITS lines of 2^OFFSET_WORDS_BITS words.
// Address split: [1:0] ignored, [3:2] word in line, [3+INDEX_BITS:4] line index,
// everything above is the tag. A hit returns its word one cycle later. A miss
// raises stall in the same cycle and refills the whole line from backing memory
// one word per req/ack handshake. After the refill, the held PC address hits.
//
// Ports:
//   clk        system clock, every register updates on posedge
//   resetIn    synchronous active-high reset; invalidates every line
//   addrIn     fetch address from the PC
//   instOut    instruction word for IF_ID (holds its value while invalid)
//   instValid  instOut is valid; high only in the cycle after a hit
//   stall      cache busy; the hazard unit holds the PC while this is high
//   memReq     refill word request
//   memAddr    refill word address (word aligned), stable until memAck
//   memAck     memory accepted the request; memData is valid
//   memData    refill data word
//
// Optional build macro ICACHE_STATS_EN adds two saturating 32-bit counters:
//   hitCount   number of LOOKUP cycles that hit
//   missCount  number of LOOKUP -> REFILL transitions
// -----------------------------------------------------------------------------
module inst_cache #(
   parameter int ADDR_WIDTH        = 32,
   parameter int INDEX_BITS        = 4,
   parameter int OFFSET_WORDS_BITS = 2
) (
   input  logic                  clk,
   input  logic                  resetIn,
   input  logic [ADDR_WIDTH-1:0] addrIn,
   output logic [ADDR_WIDTH-1:0] instOut,
   output logic                  instValid,
   output logic                  stall,
   output logic                  memReq,
   output logic [ADDR_WIDTH-1:0] memAddr,
   input  logic                  memAck,
   input  logic [ADDR_WIDTH-1:0] memData
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]           hitCount,
   output logic [31:0]           missCount
`endif
);

   localparam int LINES    = 1 << INDEX_BITS;
   localparam int WORDS    = 1 << OFFSET_WORDS_BITS;
   localparam int WORD_LSB = 2;
   localparam int IDX_LSB  = WORD_LSB + OFFSET_WORDS_BITS;
   localparam int TAG_LSB  = IDX_LSB + INDEX_BITS;
   localparam int TAG_W    = ADDR_WIDTH - TAG_LSB;

   typedef enum logic [0:0] {
      LOOKUP = 1'b0,
      REFILL = 1'b1
   } state_t;

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   state_t                         r_state;
   logic [OFFSET_WORDS_BITS-1:0]   r_cnt;          // next word of the line to fetch
   logic [TAG_W-1:0]               r_miss_tag;     // line being refilled
   logic [INDEX_BITS-1:0]          r_miss_index;
   logic [LINES-1:0]               r_valid;
   logic [TAG_W-1:0]               r_tag_mem  [LINES];
   logic [ADDR_WIDTH-1:0]          r_data_mem [LINES*WORDS];
   logic [ADDR_WIDTH-1:0]          r_inst;
   logic                           r_inst_valid;

   // ---------------------------------------------------------------------------
   // Combinational signals
   // ---------------------------------------------------------------------------
   state_t                                 w_state_next;
   logic [OFFSET_WORDS_BITS-1:0]           w_word;
   logic [INDEX_BITS-1:0]                  w_index;
   logic [TAG_W-1:0]                       w_tag;
   logic                                   w_hit;
   logic                                   w_lookup_hit;
   logic                                   w_lookup_miss;
   logic                                   w_fill_we;      // accepted refill word
   logic                                   w_fill_last;    // accepted final word
   logic [INDEX_BITS+OFFSET_WORDS_BITS-1:0] w_rd_addr;
   logic [INDEX_BITS+OFFSET_WORDS_BITS-1:0] w_wr_addr;
   logic                                   w_unused;

   // Byte offset within the word is irrelevant for an aligned fetch.
   assign w_unused = ^addrIn[WORD_LSB-1:0];

   assign w_word  = addrIn[IDX_LSB-1:WORD_LSB];
   assign w_index = addrIn[TAG_LSB-1:IDX_LSB];
   assign w_tag   = addrIn[ADDR_WIDTH-1:TAG_LSB];

   // Tag/valid lookup is combinational on the current fetch address so that a
   // miss can raise stall before the PC would otherwise advance.
   assign w_hit = r_valid[w_index] && (r_tag_mem[w_index] == w_tag);

   assign w_lookup_hit  = (r_state == LOOKUP) &&  w_hit;
   assign w_lookup_miss = (r_state == LOOKUP) && !w_hit;

   assign w_rd_addr = {w_index, w_word};
   assign w_wr_addr = {r_miss_index, r_cnt};

   // ---------------------------------------------------------------------------
   // FSM: next state and outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      stall        = 1'b0;
      memReq       = 1'b0;
      memAddr      = '0;
      w_fill_we    = 1'b0;
      w_fill_last  = 1'b0;

      unique case (r_state)
         LOOKUP: begin
            if (!w_hit) begin
               stall        = 1'b1;
               w_state_next = REFILL;
            end
         end
         REFILL: begin
            stall   = 1'b1;
            memReq  = 1'b1;
            // Address comes from the latched miss, not addrIn, so it stays
            // stable even if the PC misbehaves during the refill.
            memAddr = {r_miss_tag, r_miss_index, r_cnt, 2'b00};
            if (memAck) begin
               w_fill_we = 1'b1;
               if (r_cnt == {OFFSET_WORDS_BITS{1'b1}}) begin
                  w_fill_last  = 1'b1;
                  w_state_next = LOOKUP;
               end
            end
         end
         default: begin
            w_state_next = LOOKUP;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM state, refill counter and latched miss line
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (resetIn) begin
         r_state      <= LOOKUP;
         r_cnt        <= '0;
         r_miss_tag   <= '0;
         r_miss_index <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_lookup_miss) begin
            r_cnt        <= '0;
            r_miss_tag   <= w_tag;
            r_miss_index <= w_index;
         end else if (w_fill_we) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Valid bits: cleared by reset, set only once the whole line has arrived, so
   // an aborted refill leaves the line invalid.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (resetIn) begin
         r_valid <= '0;
      end else if (w_fill_last) begin
         r_valid[r_miss_index] <= 1'b1;
      end
   end

   // Tag store: no reset needed, the valid bit qualifies it.
   always_ff @(posedge clk) begin
      if (!resetIn && w_fill_last) begin
         r_tag_mem[r_miss_index] <= r_miss_tag;
      end
   end

   // Data store: written one word per accepted handshake. Conflicting lines are
   // simply overwritten; the cache is read-only so nothing is written back.
   always_ff @(posedge clk) begin
      if (!resetIn && w_fill_we) begin
         r_data_mem[w_wr_addr] <= memData;
      end
   end

   // ---------------------------------------------------------------------------
   // Fetch result: registered read of the data store on a hit. instOut keeps
   // its previous value in every non-hit cycle.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (resetIn) begin
         r_inst       <= '0;
         r_inst_valid <= 1'b0;
      end else begin
         r_inst_valid <= w_lookup_hit;
         if (w_lookup_hit) begin
            r_inst <= r_data_mem[w_rd_addr];
         end
      end
   end

   assign instOut   = r_inst;
   assign instValid = r_inst_valid;

`ifdef ICACHE_STATS_EN
   // ---------------------------------------------------------------------------
   // Hit/miss statistics, saturating at all-ones.
   // ---------------------------------------------------------------------------
   logic [31:0] r_hit_count;
   logic [31:0] r_miss_count;

   always_ff @(posedge clk) begin
      if (resetIn) begin
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else begin
         if (w_lookup_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
            r_hit_count <= r_hit_count + 32'd1;
         end
         if (w_lookup_miss && (r_miss_count != 32'hFFFF_FFFF)) begin
            r_miss_count <= r_miss_count + 32'd1;
         end
      end
   end

   assign hitCount  = r_hit_count;
   assign missCount = r_miss_count;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// -----------------------------------------------------------------------------
// tb_inst_cache
//
// Directed bench for inst_cache. A cache-level reference model (per-line valid,
// tag and data, plus a "refilling line base / words received" view of a miss)
// predicts stall, memReq, memAddr, instValid and instOut every cycle; a compare
// process checks them on the falling edge. Directed sequences add literal
// expectations for returned instructions, refill address sequences, stall
// length and reset behaviour. With ICACHE_STATS_EN the counters are checked too.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inst_cache;

   logic        clk     = 1'b0;
   logic        resetIn = 1'b1;
   logic [31:0] addrIn  = 32'h0;
   logic        memAck  = 1'b0;
   logic [31:0] memData = 32'h0;
   logic [31:0] instOut;
   logic        instValid;
   logic        stall;
   logic        memReq;
   logic [31:0] memAddr;
`ifdef ICACHE_STATS_EN
   logic [31:0] hitCount;
   logic [31:0] missCount;
`endif

   inst_cache #(
      .ADDR_WIDTH        (32),
      .INDEX_BITS        (4),
      .OFFSET_WORDS_BITS (2)
   ) dut (
      .clk       (clk),
      .resetIn   (resetIn),
      .addrIn    (addrIn),
      .instOut   (instOut),
      .instValid (instValid),
      .stall     (stall),
      .memReq    (memReq),
      .memAddr   (memAddr),
      .memAck    (memAck),
      .memData   (memData)
`ifdef ICACHE_STATS_EN
      ,
      .hitCount  (hitCount),
      .missCount (missCount)
`endif
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Bookkeeping
   // ---------------------------------------------------------------------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Backing memory contents: words 0x0..0xC hold 0x11..0x44, elsewhere a
   // recognisable function of the address.
   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (a < 32'h10) return ((a >> 2) + 32'd1) * 32'h11;
      return a ^ 32'hCAFE_0000;
   endfunction

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   bit          m_init   = 1'b0;
   bit          m_refill = 1'b0;
   int          m_word   = 0;
   logic [31:0] m_base   = 32'h0;
   bit          m_valid    [16];
   logic [31:0] m_line_tag [16];
   logic [31:0] m_data     [16][4];
   bit          exp_valid = 1'b0;
   logic [31:0] exp_out   = 32'h0;
   int          m_hits    = 0;
   int          m_misses  = 0;

   function automatic int line_of(input logic [31:0] a);
      return int'((a >> 4) & 32'hF);
   endfunction

   function automatic bit m_hit(input logic [31:0] a);
      return m_valid[line_of(a)] && (m_line_tag[line_of(a)] == (a >> 8));
   endfunction

   always @(posedge clk) begin
      if (resetIn) begin
         m_init    = 1'b1;
         m_refill  = 1'b0;
         m_word    = 0;
         for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
         exp_valid = 1'b0;
         exp_out   = 32'h0;
         m_hits    = 0;
         m_misses  = 0;
      end else if (m_init) begin
         if (!m_refill) begin
            if (m_hit(addrIn)) begin
               exp_valid = 1'b1;
               exp_out   = m_data[line_of(addrIn)][int'((addrIn >> 2) & 32'h3)];
               m_hits++;
            end else begin
               exp_valid = 1'b0;
               m_refill  = 1'b1;
               m_word    = 0;
               m_base    = addrIn & ~32'hF;
               m_misses++;
            end
         end else begin
            exp_valid = 1'b0;
            if (memAck) begin
               m_data[line_of(m_base)][m_word] = memData;
               m_word++;
               if (m_word == 4) begin
                  m_valid[line_of(m_base)]    = 1'b1;
                  m_line_tag[line_of(m_base)] = m_base >> 8;
                  m_refill                    = 1'b0;
               end
            end
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (m_init) begin
         check("stall", {31'd0, stall}, {31'd0, (m_refill || !m_hit(addrIn))});
         check("memReq", {31'd0, memReq}, {31'd0, m_refill});
         check("memAddr", memAddr, m_refill ? (m_base + 32'(4 * m_word)) : 32'h0);
         check("instValid", {31'd0, instValid}, {31'd0, exp_valid});
         check("instOut", instOut, exp_out);
`ifdef ICACHE_STATS_EN
         check("hitCount", hitCount, 32'(m_hits));
         check("missCount", missCount, 32'(m_misses));
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Memory responder: acks after ack_delay waiting cycles; drives 2ns after the
   // edge so the directed sequence (1ns) can hand over control cleanly.
   // ---------------------------------------------------------------------------
   int          ack_delay = 0;
   bit          resp_en   = 1'b1;
   int          wait_cnt  = 0;
   logic [31:0] ack_q [$];

   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (resp_en) begin
            memAck = 1'b0;
            if (memReq) begin
               if (wait_cnt >= ack_delay) begin
                  memAck   = 1'b1;
                  memData  = mem_val(memAddr);
                  ack_q.push_back(memAddr);
                  wait_cnt = 0;
               end else begin
                  wait_cnt++;
               end
            end else begin
               wait_cnt = 0;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Directed helpers
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Skips the current cycle (which still shows the previous hit) and waits
   // for the next instValid.
   task automatic wait_valid(input string name, output logic [31:0] d);
      bit got;
      got = 1'b0;
      d   = 32'h0;
      @(negedge clk);
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (instValid) begin
            got = 1'b1;
            d   = instOut;
         end
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: instValid not seen within 100 cycles, want 1", name);
      end
   endtask

   task automatic check_acks(input string name, input logic [31:0] base);
      check({name, "_nacks"}, 32'(ack_q.size()), 32'd4);
      for (int i = 0; i < ack_q.size() && i < 4; i++) begin
         check({name, "_ackaddr"}, ack_q[i], base + 32'(4 * i));
      end
   endtask

   logic [31:0] d;
   int          sc;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, want summary first");
      $fatal(1, "watchdog");
   end

   initial begin
      resetIn = 1'b1;
      addrIn  = 32'h0;
      repeat (2) tick();

      // 1: cold miss at 0x0, back-to-back acks
      resetIn = 1'b0;
      addrIn  = 32'h0;
      ack_q.delete();
      @(negedge clk);
      check("t1_stall_same_cycle", {31'd0, stall}, 32'd1);
      wait_valid("t1_inst", d);
      check("t1_inst", d, 32'h0000_0011);
      check_acks("t1", 32'h0);

      // 2: hit at 0x8, one-cycle latency, no request
      tick();
      addrIn = 32'h8;
      @(negedge clk);
      check("t2_stall", {31'd0, stall}, 32'd0);
      check("t2_memReq", {31'd0, memReq}, 32'd0);
      @(negedge clk);
      check("t2_valid", {31'd0, instValid}, 32'd1);
      check("t2_inst", instOut, 32'h0000_0033);
      check("t2_memReq_next", {31'd0, memReq}, 32'd0);

      // byte offset ignored: 0xE reads word 3
      tick();
      addrIn = 32'hE;
      @(negedge clk);
      @(negedge clk);
      check("t2_unaligned", instOut, 32'h0000_0044);

      // 3: conflict at index 0, then original line again
      tick();
      addrIn = 32'h104;
      ack_q.delete();
      wait_valid("t3_inst_new", d);
      check("t3_inst_new", d, 32'hCAFE_0104);
      check_acks("t3_new", 32'h100);
      tick();
      addrIn = 32'h0;
      ack_q.delete();
      wait_valid("t3_inst_old", d);
      check("t3_inst_old", d, 32'h0000_0011);
      check_acks("t3_old", 32'h0);
`ifdef ICACHE_STATS_EN
      check("t6_missCount", missCount, 32'd3);
`endif

      // 4: slow memory, 3 wait cycles per word: 1 miss + 16 refill cycles
      tick();
      ack_delay = 3;
      addrIn    = 32'h208;
      ack_q.delete();
      sc = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!stall) break;
         sc++;
      end
      check("t4_stall_cycles", 32'(sc), 32'd17);
      @(negedge clk);
      check("t4_valid", {31'd0, instValid}, 32'd1);
      check("t4_inst", instOut, 32'hCAFE_0208);
      check_acks("t4", 32'h200);
      ack_delay = 0;

      // 5: reset after two acked words of line 0x40
      tick();
      resp_en = 1'b0;
      memAck  = 1'b0;
      addrIn  = 32'h40;
      @(negedge clk);
      check("t5_miss_stall", {31'd0, stall}, 32'd1);
      tick();
      memAck  = 1'b1;
      memData = mem_val(memAddr);
      tick();
      memData = mem_val(memAddr);
      tick();
      memAck  = 1'b0;
      resetIn = 1'b1;
      tick();
      resetIn = 1'b0;
      memAck  = 1'b1;              // late ack, must be ignored
      memData = 32'hDEAD_BEEF;
      addrIn  = 32'h0;
      @(negedge clk);
      check("t5_memReq_after_reset", {31'd0, memReq}, 32'd0);
      check("t5_valid_after_reset", {31'd0, instValid}, 32'd0);
      tick();
      memAck    = 1'b0;
      ack_q.delete();
      ack_delay = 0;
      resp_en   = 1'b1;
      wait_valid("t5_inst", d);
      check("t5_inst", d, 32'h0000_0011);
      check_acks("t5", 32'h0);

      // aborted line stays invalid and refills completely
      tick();
      addrIn = 32'h40;
      ack_q.delete();
      @(negedge clk);
      check("t5_line40_invalid", {31'd0, stall}, 32'd1);
      wait_valid("t5_inst40", d);
      check("t5_inst40", d, 32'hCAFE_0040);
      check_acks("t5_40", 32'h40);

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
